// File: rtl/tdm_pkg.sv
// Shared constants, state encoding and counter sizing for the TDM receive path.
package tdm_pkg;

   localparam int unsigned N_CH_DEFAULT = 4;
   localparam int unsigned W_DEFAULT    = 8;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_e;

   // Counter width for a 0..n-1 counter, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tdm_slot_shifter.sv
// Per-slot MSB-first shifter and bit counter; flags the bit that completes a slot word.
module tdm_slot_shifter
   import tdm_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         shift_en,
   input  logic         start,
   input  logic         sdi,
   output logic [W-1:0] word_c,
   output logic         word_done_c,
   output logic         at_bit0_c
);

   localparam int unsigned BW = cnt_w(W);

   // Only W-1 bits are stored: the final bit of a word is taken straight from sdi.
   logic [W-2:0]  shift_q, shift_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [BW-1:0] pos;

   always_comb begin
      pos         = start ? '0 : bit_cnt_q;
      word_c      = {shift_q, sdi};
      word_done_c = shift_en && (pos == BW'(W - 1));
      at_bit0_c   = (bit_cnt_q == '0);
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      if (shift_en) begin
         shift_d   = word_c[W-2:0];
         bit_cnt_d = (pos == BW'(W - 1)) ? '0 : pos + BW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM receive demultiplexer: frame alignment FSM, slot counter, staging bank and
// the parallel output bank that only ever changes by a whole frame.
module tdm_demux_rx
   import tdm_pkg::*;
#(
   parameter int unsigned N_CH = N_CH_DEFAULT,
   parameter int unsigned W    = W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_en,
   input  logic              sdi,
   input  logic              fsync,
   output logic [N_CH*W-1:0] dout,
   output logic              frame_valid,
   output logic [N_CH-1:0]   ch_valid,
   output logic              locked,
   output logic              sync_err
);

   localparam int unsigned SW = cnt_w(N_CH);

   state_e              state_q, state_d;
   logic [SW-1:0]       slot_q, slot_d;
   logic [W-1:0]        stage_q [N_CH];
   logic [W-1:0]        stage_d [N_CH];
   logic [N_CH*W-1:0]   dout_q, dout_d;
   logic                frame_valid_q, frame_valid_d;
   logic [N_CH-1:0]     ch_valid_q, ch_valid_d;
   logic                locked_q, locked_d;
   logic                sync_err_q, sync_err_d;

   logic                shift_en;
   logic                frame_start;
   logic                word_done;
   logic                at_bit0;
   logic [W-1:0]        word;

   // Expected start of a frame: first bit of slot 0.
   assign frame_start = (slot_q == '0) && at_bit0;

   // A bit is consumed unless it is ignored in HUNT or dropped for a missing fsync.
   assign shift_en = bit_en && ((state_q == HUNT) ? fsync : !(frame_start && !fsync));

   tdm_slot_shifter #(
      .W (W)
   ) u_shifter (
      .clk         (clk),
      .rst_n       (rst_n),
      .shift_en    (shift_en),
      .start       (fsync),
      .sdi         (sdi),
      .word_c      (word),
      .word_done_c (word_done),
      .at_bit0_c   (at_bit0)
   );

   always_comb begin
      state_d       = state_q;
      slot_d        = slot_q;
      stage_d       = stage_q;
      dout_d        = dout_q;
      frame_valid_d = 1'b0;
      ch_valid_d    = '0;
      sync_err_d    = 1'b0;

      if (bit_en) begin
         case (state_q)
            HUNT: begin
               if (fsync) begin
                  state_d = LOCK;
                  slot_d  = '0;
               end
            end
            LOCK: begin
               if (frame_start && !fsync) begin
                  sync_err_d = 1'b1;
                  state_d    = HUNT;
               end else if (fsync) begin
                  // Early marker realigns here; the partial frame never reaches dout.
                  slot_d     = '0;
                  sync_err_d = !frame_start;
               end else if (word_done) begin
                  for (int k = 0; k < N_CH; k++) begin
                     if (SW'(k) == slot_q) begin
                        stage_d[k]    = word;
                        ch_valid_d[k] = 1'b1;
                     end
                  end
                  if (slot_q == SW'(N_CH - 1)) begin
                     slot_d        = '0;
                     frame_valid_d = 1'b1;
                     for (int k = 0; k < N_CH; k++) begin
                        dout_d[k*W +: W] = stage_d[k];
                     end
                  end else begin
                     slot_d = slot_q + SW'(1);
                  end
               end
            end
         endcase
      end

      locked_d = (state_d == LOCK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         slot_q        <= '0;
         for (int k = 0; k < N_CH; k++) begin
            stage_q[k] <= '0;
         end
         dout_q        <= '0;
         frame_valid_q <= 1'b0;
         ch_valid_q    <= '0;
         locked_q      <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         stage_q       <= stage_d;
         dout_q        <= dout_d;
         frame_valid_q <= frame_valid_d;
         ch_valid_q    <= ch_valid_d;
         locked_q      <= locked_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign dout        = dout_q;
   assign frame_valid = frame_valid_q;
   assign ch_valid    = ch_valid_q;
   assign locked      = locked_q;
   assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed bench for tdm_demux_rx (N_CH=4, W=8) with hand-computed frames.
module tb_tdm_demux_rx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bit_en;
   logic        sdi;
   logic        fsync;
   logic [31:0] dout;
   logic        frame_valid;
   logic [3:0]  ch_valid;
   logic        locked;
   logic        sync_err;

   int checks = 0;
   int errors = 0;

   // Per-stream observations
   int          fv_cnt;
   int          se_cnt;
   int          chv_err;
   int          pulse_err;
   logic        se_first;
   logic        lk_first;
   logic [31:0] dout_prev;

   tdm_demux_rx #(
      .N_CH (4),
      .W    (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_en      (bit_en),
      .sdi         (sdi),
      .fsync       (fsync),
      .dout        (dout),
      .frame_valid (frame_valid),
      .ch_valid    (ch_valid),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   // One strobed bit; outputs are read 1ns after the sampling edge.
   task automatic put_bit(input logic b, input logic f);
      @(negedge clk);
      bit_en = 1'b1;
      sdi    = b;
      fsync  = f;
      @(posedge clk);
      #1;
   endtask

   // Unstrobed cycles with junk on the line; any pulse here is an error.
   task automatic idle(input int n);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         bit_en = 1'b0;
         sdi    = 1'($urandom);
         fsync  = 1'($urandom);
         @(posedge clk);
         #1;
         if (frame_valid || sync_err || (ch_valid != 4'd0)) pulse_err++;
      end
   endtask

   task automatic send_stream(input logic [31:0] data, input int nbits, input bit fs, input int gap);
      int         slot;
      int         b;
      logic [3:0] exp_chv;
      fv_cnt    = 0;
      se_cnt    = 0;
      chv_err   = 0;
      se_first  = 1'b0;
      lk_first  = 1'b0;
      dout_prev = 32'h0;
      for (int i = 0; i < nbits; i++) begin
         slot = i / 8;
         b    = 7 - (i % 8);
         put_bit(data[slot*8 + b], fs && (i == 0));
         exp_chv = ((i % 8) == 7) ? 4'(1 << slot) : 4'd0;
         if (ch_valid !== exp_chv) chv_err++;
         fv_cnt += int'(frame_valid);
         se_cnt += int'(sync_err);
         if (i == 0) begin
            se_first = sync_err;
            lk_first = locked;
         end
         if (i == nbits - 2) dout_prev = dout;
         if ((gap > 0) && (i != nbits - 1)) idle(gap);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      bit_en    = 1'b0;
      sdi       = 1'b0;
      fsync     = 1'b0;
      pulse_err = 0;
      repeat (3) @(negedge clk);
      check("rst_dout", 64'(dout), 64'h0);
      check("rst_locked", 64'(locked), 64'h0);
      check("rst_pulses", 64'({frame_valid, ch_valid, sync_err}), 64'h0);
      rst_n = 1'b1;

      // HUNT ignores bits without fsync
      put_bit(1'b1, 1'b0);
      put_bit(1'b0, 1'b0);
      check("hunt_locked", 64'(locked), 64'h0);
      check("hunt_syncerr", 64'(sync_err), 64'h0);

      // Clean lock
      send_stream(32'h01FF3CA5, 32, 1'b1, 0);
      check("clean_dout", 64'(dout), 64'h01FF3CA5);
      check("clean_fv_last", 64'(frame_valid), 64'h1);
      check("clean_fv_cnt", 64'(fv_cnt), 64'd1);
      check("clean_chv", 64'(chv_err), 64'd0);
      check("clean_se", 64'(se_cnt), 64'd0);
      check("clean_locked", 64'(locked), 64'h1);
      check("clean_lk_first", 64'(lk_first), 64'h1);
      idle(1);
      check("clean_pulse_one_clk", 64'(pulse_err), 64'd0);

      // Continuous frame
      send_stream(32'h44332211, 32, 1'b1, 0);
      check("cont_dout_hold", 64'(dout_prev), 64'h01FF3CA5);
      check("cont_dout", 64'(dout), 64'h44332211);
      check("cont_se", 64'(se_cnt), 64'd0);
      check("cont_fv_cnt", 64'(fv_cnt), 64'd1);
      check("cont_chv", 64'(chv_err), 64'd0);

      // Missing fsync at frame start
      put_bit(1'b1, 1'b0);
      check("miss_se", 64'(sync_err), 64'h1);
      check("miss_locked", 64'(locked), 64'h0);
      check("miss_dout", 64'(dout), 64'h44332211);
      put_bit(1'b1, 1'b0);
      check("miss_se_once", 64'(sync_err), 64'h0);
      send_stream(32'h01FF3CA5, 32, 1'b1, 0);
      check("relock_dout", 64'(dout), 64'h01FF3CA5);
      check("relock_locked", 64'(locked), 64'h1);
      check("relock_se", 64'(se_cnt), 64'd0);

      // Early fsync at bit 13
      send_stream(32'hDEADBEEF, 13, 1'b1, 0);
      check("early_partial_fv", 64'(fv_cnt), 64'd0);
      check("early_partial_chv", 64'(chv_err), 64'd0);
      send_stream(32'h5A6B7C8D, 32, 1'b1, 0);
      check("early_se", 64'(se_first), 64'h1);
      check("early_se_cnt", 64'(se_cnt), 64'd1);
      check("early_locked", 64'(lk_first), 64'h1);
      check("early_dout_hold", 64'(dout_prev), 64'h01FF3CA5);
      check("early_dout", 64'(dout), 64'h5A6B7C8D);
      check("early_fv_cnt", 64'(fv_cnt), 64'd1);

      // Sparse strobes, one clock in five
      pulse_err = 0;
      send_stream(32'h01FF3CA5, 32, 1'b1, 4);
      check("sparse_dout_hold", 64'(dout_prev), 64'h5A6B7C8D);
      check("sparse_dout", 64'(dout), 64'h01FF3CA5);
      check("sparse_chv", 64'(chv_err), 64'd0);
      check("sparse_se", 64'(se_cnt), 64'd0);
      check("sparse_idle_pulses", 64'(pulse_err), 64'd0);
      check("sparse_locked", 64'(locked), 64'h1);

      // Reset mid-frame
      send_stream(32'h44332211, 20, 1'b1, 0);
      @(negedge clk);
      bit_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("midrst_dout", 64'(dout), 64'h0);
      check("midrst_locked", 64'(locked), 64'h0);
      check("midrst_pulses", 64'({frame_valid, ch_valid, sync_err}), 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      put_bit(1'b1, 1'b0);
      check("postrst_hunt", 64'(locked), 64'h0);
      send_stream(32'h44332211, 32, 1'b1, 0);
      check("postrst_dout", 64'(dout), 64'h44332211);
      check("postrst_locked", 64'(locked), 64'h1);
      check("postrst_fv_cnt", 64'(fv_cnt), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
